// File: rtl/algo_1r1w_refresh_sched_pkg.sv
// Shared types and elaboration-time helpers for the 1R1W refresh scheduler
// and its round-robin bank/row pointer.
package algo_1r1w_refresh_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PEND  = 2'd2,
    ST_FORCE = 2'd3
  } state_t;

  localparam int DEF_REFFREQ  = 6;
  localparam int DEF_MAXDEFER = 2;

  // Deferral must end (forced or not) before the next obligation can be raised.
  function automatic bit refresh_params_ok(int numpbnk, int bitpbnk, int numrow, int bitrow,
                                           int reffreq, int maxdefer, int bitfreq);
    return (reffreq >= 4) && (maxdefer >= 1) && (maxdefer <= reffreq - 3) &&
           ((1 << bitfreq) >= reffreq) && ((1 << bitpbnk) >= numpbnk) &&
           ((1 << bitrow) >= numrow) && (numpbnk >= 1) && (numrow >= 1);
  endfunction

endpackage

// File: rtl/algo_1r1w_refresh_sched_if.sv
// Core-side access and refresh-command bundle between the memory core and the
// refresh scheduler.
interface algo_1r1w_refresh_sched_if #(
  parameter int BITPBNK = 3,
  parameter int BITROW  = 8
);
  logic               refr_ena;
  logic               read;
  logic [BITPBNK-1:0] rd_bnk;
  logic               write;
  logic [BITPBNK-1:0] wr_bnk;
  logic               ready;
  logic               ref_vld;
  logic [BITPBNK-1:0] ref_bnk;
  logic [BITROW-1:0]  ref_row;
  logic               ref_err;

  modport master (
    output refr_ena, read, rd_bnk, write, wr_bnk,
    input  ready, ref_vld, ref_bnk, ref_row, ref_err
  );

  modport slave (
    input  refr_ena, read, rd_bnk, write, wr_bnk,
    output ready, ref_vld, ref_bnk, ref_row, ref_err
  );
endinterface

// File: rtl/algo_1r1w_refresh_sched_ptr.sv
// Round-robin refresh target: walks every bank of a row before moving to the
// next row, wrapping both indices.
module algo_1r1w_refresh_ptr #(
  parameter int NUMPBNK = 8,
  parameter int BITPBNK = 3,
  parameter int NUMROW  = 256,
  parameter int BITROW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  output logic [BITPBNK-1:0] bnk,
  output logic [BITROW-1:0]  row
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bnk <= '0;
      row <= '0;
    end else if (advance) begin
      if (bnk == BITPBNK'(NUMPBNK - 1)) begin
        bnk <= '0;
        row <= (row == BITROW'(NUMROW - 1)) ? '0 : row + 1'b1;
      end else begin
        bnk <= bnk + 1'b1;
      end
    end
  end

endmodule

// File: rtl/algo_1r1w_refresh_sched.sv
// Refresh scheduler: raises an obligation every REFFREQ cycles, hides it in a
// bank untouched by the core, or stalls the core one cycle to force it.
module algo_1r1w_refresh_sched
  import algo_1r1w_refresh_pkg::*;
#(
  parameter int NUMPBNK  = 8,
  parameter int BITPBNK  = 3,
  parameter int NUMROW   = 256,
  parameter int BITROW   = 8,
  parameter int REFFREQ  = DEF_REFFREQ,
  parameter int MAXDEFER = DEF_MAXDEFER,
  parameter int BITFREQ  = 3
) (
  input logic                    clk,
  input logic                    rst,
  algo_1r1w_refresh_sched_if.slave bus
);

  if (!refresh_params_ok(NUMPBNK, BITPBNK, NUMROW, BITROW, REFFREQ, MAXDEFER, BITFREQ))
  begin : g_param_err
    $error("algo_1r1w_refresh_sched: illegal parameter combination");
  end

  state_t             state_q, state_d;
  logic [BITFREQ-1:0] timer_q;
  logic [BITFREQ-1:0] age_q, age_d;
  logic               err_q;
  logic               tick;
  logic               ready;
  logic               conflict;
  logic               ref_vld;
  logic               advance;

  assign tick  = bus.refr_ena && (timer_q == BITFREQ'(REFFREQ - 1));
  assign ready = (state_q == ST_IDLE) || (state_q == ST_PEND);

  // Requests made while stalled are illegal and never block a refresh.
  assign conflict = ready && ((bus.read  && (bus.rd_bnk == bus.ref_bnk)) ||
                              (bus.write && (bus.wr_bnk == bus.ref_bnk)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      timer_q <= '0;
      age_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      if (!bus.refr_ena || tick) timer_q <= '0;
      else                       timer_q <= timer_q + 1'b1;
      if ((bus.read || bus.write) && !ready) err_q <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    ref_vld = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_PEND;
          age_d   = '0;
        end
      end
      ST_PEND: begin
        if (!bus.refr_ena) begin
          state_d = ST_IDLE;
        end else if (!conflict) begin
          ref_vld = 1'b1;
          advance = 1'b1;
          state_d = ST_IDLE;
        end else if (age_q == BITFREQ'(MAXDEFER - 1)) begin
          state_d = ST_FORCE;
        end else begin
          age_d = age_q + 1'b1;
        end
      end
      ST_FORCE: begin
        state_d = ST_IDLE;
        if (bus.refr_ena) begin
          ref_vld = 1'b1;
          advance = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  algo_1r1w_refresh_ptr #(
    .NUMPBNK(NUMPBNK),
    .BITPBNK(BITPBNK),
    .NUMROW (NUMROW),
    .BITROW (BITROW)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .advance(advance),
    .bnk    (bus.ref_bnk),
    .row    (bus.ref_row)
  );

  assign bus.ready   = ready;
  assign bus.ref_vld = ref_vld;
  assign bus.ref_err = err_q;

endmodule

// File: tb/tb_algo_1r1w_refresh_sched.sv
// Directed bench for the refresh scheduler: 4 banks x 4 rows, REFFREQ=6,
// MAXDEFER=2; expected values are hand-derived cycle by cycle.
module tb_algo_1r1w_refresh_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  algo_1r1w_refresh_sched_if #(.BITPBNK(2), .BITROW(2)) bus ();

  algo_1r1w_refresh_sched #(
    .NUMPBNK (4),
    .BITPBNK (2),
    .NUMROW  (4),
    .BITROW  (2),
    .REFFREQ (6),
    .MAXDEFER(2),
    .BITFREQ (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Land 1 time unit after the rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [1:0] rb, input logic wr, input logic [1:0] wb);
    bus.read   = rd;
    bus.rd_bnk = rb;
    bus.write  = wr;
    bus.wr_bnk = wb;
    #1;
  endtask

  // Advance until ref_vld is seen; n = cycles taken, or limit+1 if it never came.
  task automatic wait_vld(input int limit, output int n);
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      cyc();
      if (bus.ref_vld) begin
        n = i;
        break;
      end
    end
  endtask

  // A strobe must never land on a bank the core is legally touching.
  always @(negedge clk) begin
    if (rst) begin
      assert (!(bus.ready && bus.ref_vld &&
                ((bus.read && bus.rd_bnk == bus.ref_bnk) ||
                 (bus.write && bus.wr_bnk == bus.ref_bnk))))
      else begin
        errors++;
        $error("FAIL collision observed ref_bnk=%0d expected no same-bank access", bus.ref_bnk);
      end
    end
  end

  initial begin
    int n;
    bus.refr_ena = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 2'd0);

    // Reset values while held
    cyc();
    cyc();
    check("rst_ready",   32'(bus.ready),   32'd0);
    check("rst_ref_vld", 32'(bus.ref_vld), 32'd0);
    check("rst_ref_bnk", 32'(bus.ref_bnk), 32'd0);
    check("rst_ref_row", 32'(bus.ref_row), 32'd0);
    check("rst_ref_err", 32'(bus.ref_err), 32'd0);

    // 1. Release: cycle 0 not ready, ready from cycle 1, first strobe at cycle 6
    rst = 1'b1;
    #1;
    check("t1_c0_ready", 32'(bus.ready), 32'd0);
    cyc();
    check("t1_c1_ready", 32'(bus.ready),   32'd1);
    check("t1_c1_vld",   32'(bus.ref_vld), 32'd0);
    wait_vld(20, n);
    check("t1_first_gap", 32'(n), 32'd5);
    check("t1_first_bnk", 32'(bus.ref_bnk), 32'd0);
    check("t1_first_row", 32'(bus.ref_row), 32'd0);
    wait_vld(20, n);
    check("t1_period",  32'(n), 32'd6);
    check("t1_sec_bnk", 32'(bus.ref_bnk), 32'd1);
    check("t1_sec_row", 32'(bus.ref_row), 32'd0);

    // 2. Refreshes 2..16: bank-first rotation with row wrap back to 0/0
    for (int k = 2; k <= 16; k++) begin
      wait_vld(20, n);
      check("t2_period", 32'(n), 32'd6);
      check($sformatf("t2_bnk_%0d", k), 32'(bus.ref_bnk), 32'(k % 4));
      check($sformatf("t2_row_%0d", k), 32'(bus.ref_row), 32'((k / 4) % 4));
    end

    // 3. Pending on bank 1: one read conflict, then a write elsewhere
    for (int i = 0; i < 5; i++) cyc();
    check("t3_idle_vld", 32'(bus.ref_vld), 32'd0);
    cyc();
    drive(1'b1, 2'd1, 1'b0, 2'd0);
    check("t3_conf_vld",   32'(bus.ref_vld), 32'd0);
    check("t3_conf_ready", 32'(bus.ready),   32'd1);
    cyc();
    drive(1'b0, 2'd0, 1'b1, 2'd2);
    check("t3_vld",   32'(bus.ref_vld), 32'd1);
    check("t3_bnk",   32'(bus.ref_bnk), 32'd1);
    check("t3_ready", 32'(bus.ready),   32'd1);
    cyc();
    drive(1'b0, 2'd0, 1'b0, 2'd0);

    // 4. Pending on bank 0 row 1, blocked twice -> one-cycle forced stall
    wait_vld(20, n);
    check("t4_pre1_gap", 32'(n), 32'd4);
    check("t4_pre1_bnk", 32'(bus.ref_bnk), 32'd2);
    wait_vld(20, n);
    check("t4_pre2_bnk", 32'(bus.ref_bnk), 32'd3);
    for (int i = 0; i < 5; i++) cyc();
    cyc();
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    check("t4_p0_vld",   32'(bus.ref_vld), 32'd0);
    check("t4_p0_ready", 32'(bus.ready),   32'd1);
    check("t4_p0_err",   32'(bus.ref_err), 32'd0);
    cyc();
    check("t4_p1_vld",   32'(bus.ref_vld), 32'd0);
    check("t4_p1_ready", 32'(bus.ready),   32'd1);
    cyc();
    check("t4_force_ready", 32'(bus.ready),   32'd0);
    check("t4_force_vld",   32'(bus.ref_vld), 32'd1);
    check("t4_force_bnk",   32'(bus.ref_bnk), 32'd0);
    check("t4_force_row",   32'(bus.ref_row), 32'd1);
    cyc();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("t4_after_ready", 32'(bus.ready),   32'd1);
    check("t4_after_vld",   32'(bus.ref_vld), 32'd0);
    check("t4_after_err",   32'(bus.ref_err), 32'd1);
    check("t4_after_bnk",   32'(bus.ref_bnk), 32'd1);

    // 5. Disable inside PEND: obligation dropped, timer restarts on re-enable
    cyc();
    cyc();
    cyc();
    bus.refr_ena = 1'b0;
    #1;
    check("t5_drop_vld",   32'(bus.ref_vld), 32'd0);
    check("t5_drop_ready", 32'(bus.ready),   32'd1);
    for (int i = 0; i < 7; i++) cyc();
    check("t5_off_vld",   32'(bus.ref_vld), 32'd0);
    check("t5_off_ready", 32'(bus.ready),   32'd1);
    check("t5_off_bnk",   32'(bus.ref_bnk), 32'd1);
    check("t5_off_row",   32'(bus.ref_row), 32'd1);
    cyc();
    bus.refr_ena = 1'b1;
    #1;
    wait_vld(20, n);
    check("t5_reen_gap", 32'(n), 32'd6);
    check("t5_reen_bnk", 32'(bus.ref_bnk), 32'd1);
    check("t5_reen_row", 32'(bus.ref_row), 32'd1);
    check("t5_err_sticky", 32'(bus.ref_err), 32'd1);

    // 6. Async reset in the middle of FORCE, then the start-up sequence again
    for (int i = 0; i < 5; i++) cyc();
    cyc();
    drive(1'b1, 2'd2, 1'b0, 2'd0);
    cyc();
    cyc();
    check("t6_force_ready", 32'(bus.ready),   32'd0);
    check("t6_force_vld",   32'(bus.ref_vld), 32'd1);
    check("t6_force_bnk",   32'(bus.ref_bnk), 32'd2);
    rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 2'd0);
    check("t6_rst_ready", 32'(bus.ready),   32'd0);
    check("t6_rst_vld",   32'(bus.ref_vld), 32'd0);
    check("t6_rst_bnk",   32'(bus.ref_bnk), 32'd0);
    check("t6_rst_row",   32'(bus.ref_row), 32'd0);
    check("t6_rst_err",   32'(bus.ref_err), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("t6_c0_ready", 32'(bus.ready), 32'd0);
    cyc();
    check("t6_c1_ready", 32'(bus.ready), 32'd1);
    wait_vld(20, n);
    check("t6_first_gap", 32'(n), 32'd5);
    check("t6_first_bnk", 32'(bus.ref_bnk), 32'd0);
    check("t6_first_row", 32'(bus.ref_row), 32'd0);
    wait_vld(20, n);
    check("t6_period",  32'(n), 32'd6);
    check("t6_sec_bnk", 32'(bus.ref_bnk), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
